// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes (driven by ALU control), execute-unit FSM states, datapath width.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SHL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SHL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // Every code 0000..0111 is assigned; anything with the top bit set is illegal.
  function automatic logic is_legal(input logic [3:0] op);
    return !op[3];
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Single-bit shifter; the execute unit iterates it once per cycle for multi-bit shifts.
module alu_shift_step
  import cpu_pkg::ALU_SHL, cpu_pkg::ALU_SRL, cpu_pkg::ALU_SRA;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_op)
      ALU_SHL: o_data = {i_data[XLEN-2:0], 1'b0};
      ALU_SRL: o_data = {1'b0, i_data[XLEN-1:1]};
      ALU_SRA: o_data = {i_data[XLEN-1], i_data[XLEN-1:1]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith, iterative 1-bit/cycle shifts, valid/ready on both sides.
module alu_exec_unit
  import cpu_pkg::state_t, cpu_pkg::IDLE, cpu_pkg::SHIFT, cpu_pkg::HOLD,
         cpu_pkg::ALU_AND, cpu_pkg::ALU_OR, cpu_pkg::ALU_ADD, cpu_pkg::ALU_SUB,
         cpu_pkg::ALU_SLT, cpu_pkg::ALU_SHL, cpu_pkg::ALU_SRL, cpu_pkg::ALU_SRA,
         cpu_pkg::is_shift, cpu_pkg::is_legal;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  state_t               r_state, w_nxt_state;
  logic                 r_out_valid, w_nxt_ov;
  logic [XLEN-1:0]      r_result, w_nxt_res;
  logic                 r_zero, w_nxt_zero;
  logic                 r_illegal, w_nxt_ill;
  logic [SHAMT_W-1:0]   r_cnt, w_nxt_cnt;
  logic [XLEN-1:0]      r_work, w_nxt_work;
  logic [3:0]           r_op, w_nxt_op;

  logic [SHAMT_W-1:0]   w_shamt;
  logic [XLEN-1:0]      w_step_in, w_step_out, w_alu, w_wval;
  logic [3:0]           w_step_op;
  logic                 w_accept, w_wr, w_will;

  assign w_shamt  = operand_b[SHAMT_W-1:0];
  assign in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // The one shifter serves both the first bit at accept and the iterations in SHIFT.
  assign w_step_in = (r_state == SHIFT) ? r_work : operand_a;
  assign w_step_op = (r_state == SHIFT) ? r_op   : ALUControl;

  alu_shift_step #(.XLEN(XLEN)) u_step (
    .i_op   (w_step_op),
    .i_data (w_step_in),
    .o_data (w_step_out)
  );

  always_comb begin
    w_alu = '0;
    case (ALUControl)
      ALU_AND: w_alu = operand_a & operand_b;
      ALU_OR:  w_alu = operand_a | operand_b;
      ALU_ADD: w_alu = operand_a + operand_b;
      ALU_SUB: w_alu = operand_a - operand_b;
      ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      ALU_SHL, ALU_SRL, ALU_SRA: w_alu = (w_shamt == '0) ? operand_a : w_step_out;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ov    = r_out_valid;
    w_nxt_res   = r_result;
    w_nxt_zero  = r_zero;
    w_nxt_ill   = r_illegal;
    w_nxt_cnt   = r_cnt;
    w_nxt_work  = r_work;
    w_nxt_op    = r_op;
    w_wr        = 1'b0;
    w_wval      = '0;
    w_will      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_out_valid && out_ready) w_nxt_ov = 1'b0;
        if (w_accept) begin
          if (is_shift(ALUControl) && (w_shamt[SHAMT_W-1:1] != '0)) begin
            w_nxt_work  = w_step_out;
            w_nxt_cnt   = w_shamt - 1'b1;
            w_nxt_op    = ALUControl;
            w_nxt_state = SHIFT;
          end else begin
            w_wr        = 1'b1;
            w_wval      = w_alu;
            w_will      = !is_legal(ALUControl);
            w_nxt_state = out_ready ? IDLE : HOLD;
          end
        end
      end
      SHIFT: begin
        w_nxt_work = w_step_out;
        w_nxt_cnt  = r_cnt - 1'b1;
        if (r_cnt == SHAMT_W'(1)) begin
          w_wr        = 1'b1;
          w_wval      = w_step_out;
          w_nxt_state = out_ready ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_nxt_ov    = 1'b0;
          w_nxt_state = IDLE;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
    // zero is derived from the value being written, so it always matches result.
    if (w_wr) begin
      w_nxt_res  = w_wval;
      w_nxt_zero = (w_wval == '0);
      w_nxt_ill  = w_will;
      w_nxt_ov   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_cnt       <= '0;
      r_work      <= '0;
      r_op        <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_out_valid <= w_nxt_ov;
      r_result    <= w_nxt_res;
      r_zero      <= w_nxt_zero;
      r_illegal   <= w_nxt_ill;
      r_cnt       <= w_nxt_cnt;
      r_work      <= w_nxt_work;
      r_op        <= w_nxt_op;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expectations, a monitor checks each output.
module tb_alu_exec_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ALUControl = 4'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: latency checked at first sighting of out_valid, values at the handshake.
  bit seen = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", result);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc), 32'(q[0].cyc));
          seen = 1'b1;
        end
        if (out_ready) begin
          chk("result", result, q[0].res);
          chk("zero", {31'b0, zero}, {31'b0, q[0].z});
          chk("illegal", {31'b0, illegal}, {31'b0, q[0].ill});
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eill, input int lat, input bit push);
    int acc;
    bit ok;
    ALUControl = op;
    operand_a  = a;
    operand_b  = b;
    in_valid   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
      in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    @(posedge clk);
    if (push) q.push_back('{res: er, z: (er == 32'h0), ill: eill, cyc: acc + lat - 1});
    @(negedge clk);
    in_valid   = 1'b0;
    ALUControl = 4'($urandom);
    operand_a  = $urandom;
    operand_b  = $urandom;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h0);
    chk("rst_illegal", {31'b0, illegal}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    issue(ALU_ADD, 32'h5, 32'h7, 32'hC, 1'b0, 1, 1'b1);
    issue(ALU_SUB, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0, 1, 1'b1);
    issue(ALU_SUB, 32'h3, 32'h3, 32'h0, 1'b0, 1, 1'b1);
    chk("b2b_in_ready", {31'b0, in_ready}, 32'h1);
    issue(ALU_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 1'b0, 1, 1'b1);
    issue(ALU_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1, 1'b1);
    issue(ALU_OR, 32'h00001200, 32'h00000034, 32'h00001234, 1'b0, 1, 1'b1);

    issue(ALU_SHL, 32'h1, 32'h1F, 32'h80000000, 1'b0, 31, 1'b1);
    for (int i = 0; i < 30; i++) begin
      chk("shift_in_ready", {31'b0, in_ready}, 32'h0);
      @(negedge clk);
    end
    issue(ALU_SRA, 32'h80000000, 32'h104, 32'hF8000000, 1'b0, 4, 1'b1);
    issue(ALU_SRL, 32'h80000000, 32'h4, 32'h08000000, 1'b0, 4, 1'b1);
    issue(ALU_SHL, 32'h3, 32'h20, 32'h3, 1'b0, 1, 1'b1);
    issue(ALU_SRA, 32'h80000001, 32'h1, 32'hC0000000, 1'b0, 1, 1'b1);
    issue(ALU_SRL, 32'hC, 32'h2, 32'h3, 1'b0, 2, 1'b1);
    issue(ALU_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1, 1'b1);
    issue(ALU_SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 1, 1'b1);
    issue(4'b1111, 32'h12345678, 32'h1, 32'h0, 1'b1, 1, 1'b1);
    issue(4'b1000, 32'h5, 32'h5, 32'h0, 1'b1, 1, 1'b1);

    // Stall the consumer, then drain and accept on the same edge.
    issue(ALU_ADD, 32'h10, 32'h20, 32'h30, 1'b0, 1, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("hold_result", result, 32'h30);
      chk("hold_out_valid", {31'b0, out_valid}, 32'h1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'h0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue(ALU_ADD, 32'h1, 32'h2, 32'h3, 1'b0, 1, 1'b1);
    @(negedge clk);

    // Consumer not ready at the write edge: unit parks in HOLD.
    out_ready = 1'b0;
    issue(ALU_SLT, 32'hFFFFFFFE, 32'h3, 32'h1, 1'b0, 1, 1'b1);
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("holdst_in_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk);

    // Asynchronous reset in the middle of a long shift.
    issue(ALU_SHL, 32'h5, 32'd20, 32'h0, 1'b0, 20, 1'b0);
    repeat (8) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'h0);
    issue(ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1, 1'b1);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
